trace_packet_fifo: RTL and testbench

- Elastic buffer between the tracing state machine and the USB packet assembler/FIFO writer.
- Absorbs bursts of trace packets: one per RAM clock at peak, versus a slower USB drain rate.
- On overflow it drops packets, counts the drops, and inserts one marker entry when space returns. The host can therefore detect and size every gap in the trace.

---
 rtl/trace_pkg.sv | 23 ++
 rtl/trace_fifo_ram.sv | 22 ++
 rtl/trace_packet_fifo.sv | 160 ++++++++++++++++
 tb/tb_trace_packet_fifo.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the trace packet FIFO.
package trace_pkg;

  localparam logic [1:0] PKT_ADDR   = 2'b00;
  localparam logic [1:0] PKT_READ   = 2'b01;
  localparam logic [1:0] PKT_WRITE  = 2'b10;
  localparam logic [1:0] PKT_TSTAMP = 2'b11;

  localparam int TRACE_PAYLOAD_W = 23;
  localparam int TRACE_ENTRY_W   = 26;

  typedef enum logic {
    NORMAL = 1'b0,
    DROP   = 1'b1
  } mode_e;

  typedef struct packed {
    logic                       marker;
    logic [1:0]                 ptype;
    logic [TRACE_PAYLOAD_W-1:0] payload;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_ram.sv
// Simple dual-port RAM: one write port, one read port with registered read data.
module trace_fifo_ram #(
  parameter int WIDTH  = 26,
  parameter int ADDR_W = 9
) (
  input  logic              mclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge mclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/trace_packet_fifo.sv
// Elastic trace packet buffer with drop counting and overflow markers.
// Optional TRACE_FIFO_HWM_EN adds the hwm (high-water mark) output.
module trace_packet_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int DROP_W     = 22
) (
  input  logic                       mclk,
  input  logic                       reset,
  input  logic                       in_strobe,
  input  logic [1:0]                 in_type,
  input  logic [TRACE_PAYLOAD_W-1:0] in_payload,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 out_type,
  output logic [TRACE_PAYLOAD_W-1:0] out_payload,
  output logic                       out_marker,
  output logic [DEPTH_LOG2:0]        level,
`ifdef TRACE_FIFO_HWM_EN
  output logic [DEPTH_LOG2:0]        hwm,
`endif
  output logic                       overflow_sticky
);

  localparam logic [DEPTH_LOG2:0] FULL_LEVEL  = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] MARKER_ROOM = (DEPTH_LOG2+1)'(2);
  localparam logic [DROP_W-1:0]   DROP_MAX    = '1;

  mode_e                    mode, mode_next;
  logic [DROP_W-1:0]        drop_count;
  logic [DEPTH_LOG2-1:0]    wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]      ram_count, free_entries;
  logic                     q_valid, full, pop, load_out, ram_read;
  logic                     wr_en, drop_start, drop_inc, marker_write;
  trace_entry_t             wr_entry, out_entry;
  logic [TRACE_ENTRY_W-1:0] ram_rdata;

  assign pop          = out_valid && out_ready;
  assign full         = (level == FULL_LEVEL);
  assign free_entries = FULL_LEVEL - level;
  // Output register refills from the RAM read stage, which in turn prefetches so pops never bubble.
  assign load_out     = q_valid && (!out_valid || pop);
  assign ram_read     = (ram_count != '0) && (!q_valid || load_out);

  assign out_marker  = out_entry.marker;
  assign out_type    = out_entry.ptype;
  assign out_payload = out_entry.payload;

  always_comb begin
    mode_next        = mode;
    wr_en            = 1'b0;
    drop_start       = 1'b0;
    drop_inc         = 1'b0;
    marker_write     = 1'b0;
    wr_entry.marker  = 1'b0;
    wr_entry.ptype   = in_type;
    wr_entry.payload = in_payload;
    case (mode)
      NORMAL: begin
        if (in_strobe) begin
          if (!full) begin
            wr_en = 1'b1;
          end else begin
            drop_start = 1'b1;
            mode_next  = DROP;
          end
        end
      end
      DROP: begin
        // A strobe always wins over the marker so the reported count covers every lost packet.
        if (in_strobe) begin
          drop_inc = 1'b1;
        end else if (free_entries >= MARKER_ROOM) begin
          wr_en            = 1'b1;
          marker_write     = 1'b1;
          mode_next        = NORMAL;
          wr_entry.marker  = 1'b1;
          wr_entry.ptype   = PKT_TSTAMP;
          wr_entry.payload = TRACE_PAYLOAD_W'(drop_count);
        end
      end
      default: mode_next = NORMAL;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) mode <= NORMAL;
    else       mode <= mode_next;
  end

  trace_fifo_ram #(
    .WIDTH  (TRACE_ENTRY_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .mclk    (mclk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .rd_en   (ram_read),
    .rd_addr (rd_ptr),
    .rd_data (ram_rdata)
  );

  always_ff @(posedge mclk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      ram_count       <= '0;
      level           <= '0;
      q_valid         <= 1'b0;
      out_valid       <= 1'b0;
      out_entry       <= '0;
      drop_count      <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
      if (ram_read) rd_ptr <= rd_ptr + 1'b1;

      case ({wr_en, ram_read})
        2'b10:   ram_count <= ram_count + 1'b1;
        2'b01:   ram_count <= ram_count - 1'b1;
        default: ram_count <= ram_count;
      endcase

      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase

      if (ram_read)      q_valid <= 1'b1;
      else if (load_out) q_valid <= 1'b0;

      if (load_out) begin
        out_valid <= 1'b1;
        out_entry <= ram_rdata;
      end else if (pop) begin
        out_valid <= 1'b0;
      end

      if (drop_start) begin
        drop_count      <= DROP_W'(1);
        overflow_sticky <= 1'b1;
      end else if (drop_inc) begin
        if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
      end else if (marker_write) begin
        drop_count <= '0;
      end
    end
  end

`ifdef TRACE_FIFO_HWM_EN
  always_ff @(posedge mclk) begin
    if (reset)             hwm <= '0;
    else if (level > hwm)  hwm <= level;
  end
`endif

endmodule

// File: tb/tb_trace_packet_fifo.sv
// Scoreboard bench for trace_packet_fifo: a full-size instance plus a tiny one for counter saturation.
module tb_trace_packet_fifo;
  import trace_pkg::*;

  logic        mclk = 1'b0;
  logic        reset;

  logic        in_strobe, out_valid, out_ready, out_marker, overflow_sticky;
  logic [1:0]  in_type, out_type;
  logic [22:0] in_payload, out_payload;
  logic [9:0]  level;

  logic        s_in_strobe, s_out_valid, s_out_ready, s_out_marker, s_overflow_sticky;
  logic [1:0]  s_in_type, s_out_type;
  logic [22:0] s_in_payload, s_out_payload;
  logic [2:0]  s_level;
`ifdef TRACE_FIFO_HWM_EN
  logic [9:0]  hwm;
  logic [2:0]  s_hwm;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [TRACE_ENTRY_W-1:0] sb[$];
  logic [TRACE_ENTRY_W-1:0] sb_s[$];

  always #5 mclk = ~mclk;

  trace_packet_fifo dut (
    .mclk(mclk), .reset(reset), .in_strobe(in_strobe), .in_type(in_type),
    .in_payload(in_payload), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_payload(out_payload), .out_marker(out_marker),
    .level(level),
`ifdef TRACE_FIFO_HWM_EN
    .hwm(hwm),
`endif
    .overflow_sticky(overflow_sticky)
  );

  trace_packet_fifo #(.DEPTH_LOG2(2), .DROP_W(3)) dut_small (
    .mclk(mclk), .reset(reset), .in_strobe(s_in_strobe), .in_type(s_in_type),
    .in_payload(s_in_payload), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_type(s_out_type), .out_payload(s_out_payload), .out_marker(s_out_marker),
    .level(s_level),
`ifdef TRACE_FIFO_HWM_EN
    .hwm(s_hwm),
`endif
    .overflow_sticky(s_overflow_sticky)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic applyStimulus(input bit strobe, input logic [1:0] t, input logic [22:0] p, input bit accept);
    in_strobe  = strobe;
    in_type    = t;
    in_payload = p;
    if (strobe && accept) sb.push_back({1'b0, t, p});
    tick();
    in_strobe = 1'b0;
  endtask

  task automatic drainAll(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((level != 0 || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    if (n >= budget) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: level 0x%0h, %0d entries still expected", level, sb.size());
    end
    checkOutput("drain_level", 32'(level), 32'd0);
    checkOutput("drain_sb_left", 32'(sb.size()), 32'd0);
  endtask

  task automatic fillFull();
    out_ready = 1'b0;
    for (int i = 0; i < 512; i++) applyStimulus(1'b1, 2'(i), 23'(i * 3 + 5), 1'b1);
  endtask

  // Monitors pop expected entries whenever the consumer takes one.
  always @(negedge mclk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL pop_unexpected: got entry 0x%0h, required none", {out_marker, out_type, out_payload});
      end else begin
        checkOutput("pop_entry", 32'({out_marker, out_type, out_payload}), 32'(sb.pop_front()));
      end
    end
  end

  always @(negedge mclk) begin
    if (reset === 1'b0 && s_out_valid === 1'b1 && s_out_ready === 1'b1) begin
      if (sb_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL small_pop_unexpected: got entry 0x%0h, required none", {s_out_marker, s_out_type, s_out_payload});
      end else begin
        checkOutput("small_pop_entry", 32'({s_out_marker, s_out_type, s_out_payload}), 32'(sb_s.pop_front()));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1;
    in_strobe = 1'b0; in_type = '0; in_payload = '0; out_ready = 1'b0;
    s_in_strobe = 1'b0; s_in_type = '0; s_in_payload = '0; s_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset values");
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_type", 32'(out_type), 32'd0);
    checkOutput("rst_out_payload", 32'(out_payload), 32'd0);
    checkOutput("rst_out_marker", 32'(out_marker), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_sticky", 32'(overflow_sticky), 32'd0);

    $display("[TB] single push latency");
    out_ready = 1'b1;
    applyStimulus(1'b1, PKT_READ, 23'h12345, 1'b1);
    checkOutput("lat_e0_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    checkOutput("lat_e2_valid", 32'(out_valid), 32'd1);
    checkOutput("lat_e2_type", 32'(out_type), 32'd1);
    checkOutput("lat_e2_payload", 32'(out_payload), 32'h12345);
    checkOutput("lat_e2_marker", 32'(out_marker), 32'd0);
    checkOutput("lat_e2_level", 32'(level), 32'd1);
    tick();
    checkOutput("lat_e3_level", 32'(level), 32'd0);
    checkOutput("lat_e3_valid", 32'(out_valid), 32'd0);

    $display("[TB] simultaneous push and pop");
    out_ready = 1'b0;
    applyStimulus(1'b1, PKT_ADDR, 23'h00AAA, 1'b1);
    applyStimulus(1'b1, PKT_WRITE, 23'h7FFFFF, 1'b1);
    applyStimulus(1'b1, PKT_TSTAMP, 23'h000001, 1'b1);
    checkOutput("stream_level_pre", 32'(level), 32'd3);
    out_ready = 1'b1;
    applyStimulus(1'b1, PKT_READ, 23'h2AAAAA, 1'b1);
    applyStimulus(1'b1, PKT_ADDR, 23'h155555, 1'b1);
    applyStimulus(1'b1, PKT_WRITE, 23'h000100, 1'b1);
    applyStimulus(1'b1, PKT_TSTAMP, 23'h3C0F0F, 1'b1);
    applyStimulus(1'b1, PKT_READ, 23'h000000, 1'b1);
    checkOutput("stream_level_post", 32'(level), 32'd3);
    drainAll(20);

    $display("[TB] fill to full and overflow marker");
    fillFull();
    checkOutput("full_level", 32'(level), 32'd512);
    checkOutput("full_sticky", 32'(overflow_sticky), 32'd0);
    applyStimulus(1'b1, PKT_TSTAMP, 23'h55, 1'b0);
    checkOutput("drop1_sticky", 32'(overflow_sticky), 32'd1);
    checkOutput("drop1_level", 32'(level), 32'd512);
`ifdef TRACE_FIFO_HWM_EN
    checkOutput("hwm_full", 32'(hwm), 32'd512);
`endif
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, PKT_ADDR, 23'(i), 1'b0);
    checkOutput("drop5_level", 32'(level), 32'd512);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    checkOutput("drain2_level", 32'(level), 32'd510);
    sb.push_back({1'b1, PKT_TSTAMP, 23'd5});
    tick();
    checkOutput("marker_level", 32'(level), 32'd511);
    applyStimulus(1'b1, PKT_ADDR, 23'h2AAAA, 1'b1);
    drainAll(1200);
    checkOutput("post_drain_sticky", 32'(overflow_sticky), 32'd1);

    $display("[TB] strobe collision with marker");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst2_sticky", 32'(overflow_sticky), 32'd0);
    fillFull();
    applyStimulus(1'b1, PKT_READ, 23'h1, 1'b0);
    out_ready = 1'b1;
    applyStimulus(1'b1, PKT_READ, 23'h2, 1'b0);
    applyStimulus(1'b1, PKT_READ, 23'h3, 1'b0);
    out_ready = 1'b0;
    checkOutput("coll_level_free2", 32'(level), 32'd510);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, PKT_WRITE, 23'(i + 16), 1'b0);
    checkOutput("coll_level_no_marker", 32'(level), 32'd510);
    sb.push_back({1'b1, PKT_TSTAMP, 23'd7});
    tick();
    checkOutput("coll_level_marker", 32'(level), 32'd511);
    drainAll(1200);

    $display("[TB] reset mid-burst with pending marker");
    fillFull();
    out_ready = 1'b1;
    for (int i = 0; i < 502; i++) applyStimulus(1'b1, PKT_ADDR, 23'(i), 1'b0);
    checkOutput("burst_level", 32'(level), 32'd10);
    out_ready = 1'b0;
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_level", 32'(level), 32'd0);
    checkOutput("mid_rst_sticky", 32'(overflow_sticky), 32'd0);
    out_ready = 1'b1;
    applyStimulus(1'b1, PKT_WRITE, 23'h3C3C3, 1'b1);
    tick();
    tick();
    tick();
    checkOutput("after_rst_sb_left", 32'(sb.size()), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("after_rst_level", 32'(level), 32'd0);
    checkOutput("after_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 4; i++) begin
      s_in_strobe = 1'b1; s_in_type = 2'(i); s_in_payload = 23'(i + 100);
      sb_s.push_back({1'b0, 2'(i), 23'(i + 100)});
      tick();
    end
    checkOutput("small_full_level", 32'(s_level), 32'd4);
    for (int i = 0; i < 10; i++) begin
      s_in_type = PKT_ADDR; s_in_payload = 23'(i);
      tick();
    end
    s_in_strobe = 1'b0;
    checkOutput("small_drop_level", 32'(s_level), 32'd4);
    checkOutput("small_sticky", 32'(s_overflow_sticky), 32'd1);
    sb_s.push_back({1'b1, PKT_TSTAMP, 23'd7});
    s_out_ready = 1'b1;
    n = 0;
    while ((s_level != 0 || sb_s.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    s_out_ready = 1'b0;
    if (n >= 40) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL small_drain_timeout: level 0x%0h, %0d entries still expected", s_level, sb_s.size());
    end
    checkOutput("small_drain_level", 32'(s_level), 32'd0);
    checkOutput("small_sb_left", 32'(sb_s.size()), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
